// File: rtl/uart_rx_parity_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : uart_rx_parity_if
//  Brief    : Serial line input and received-byte outputs of uart_rx_parity
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface uart_rx_parity_if;
    logic       rxd;
    logic [7:0] data_out;
    logic       rdy_rx;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Line/system side: drives the serial line, consumes received bytes.
    modport master (
        output rxd,
        input  data_out,
        input  rdy_rx,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  rxd,
        output data_out,
        output rdy_rx,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_parity.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : uart_rx_parity
//  Brief    : 8E1 UART receiver, oversampled with mid-bit 3-sample majority vote
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module uart_rx_parity #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int OVS    = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_parity_if.slave bus
);

    localparam int DIV   = CLK_HZ / (BAUD * OVS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OVS_W = $clog2(OVS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OVS_W-1:0] TICK_S0   = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] TICK_S1   = OVS_W'(OVS / 2);
    localparam logic [OVS_W-1:0] TICK_DEC  = OVS_W'(OVS / 2 + 1);
    localparam logic [OVS_W-1:0] TICK_LAST = OVS_W'(OVS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OVS_W-1:0] r_tick_cnt;
    logic [1:0]       r_samp;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             r_par;
    logic [7:0]       r_data;
    logic             r_perr;
    logic             r_ferr;
    logic             r_rdy;

    logic             w_rx_s;
    logic             w_tick;
    logic             w_dec;
    logic             w_vote;
    logic             w_busy;
    logic             w_load;
    logic             w_cnt_clr;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
    assign w_dec  = w_tick && (r_tick_cnt == TICK_DEC);
    // Third sample is taken live at the decision tick.
    assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx_s) w_next_state = S_START;
            S_START:  if (w_dec) w_next_state = w_vote ? S_IDLE : S_DATA;
            S_DATA:   if (w_dec && (r_bit_idx == 3'd7)) w_next_state = S_PARITY;
            S_PARITY: if (w_dec) w_next_state = S_STOP;
            S_STOP:   if (w_dec) w_next_state = w_vote ? S_IDLE : S_BREAK;
            S_BREAK:  if (w_tick && (r_tick_cnt == TICK_LAST) && w_rx_s) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_load = (r_state == S_STOP) && w_dec;
    end

    // In BREAK any low on the line restarts the full-bit high-time measurement.
    assign w_cnt_clr = (r_state == S_IDLE)
                    || ((r_state == S_BREAK) && !w_rx_s)
                    || ((r_state == S_STOP) && w_dec && !w_vote);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp    <= 2'b11;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
        end else begin
            if (w_tick && (r_tick_cnt == TICK_S0)) r_samp[0] <= w_rx_s;
            if (w_tick && (r_tick_cnt == TICK_S1)) r_samp[1] <= w_rx_s;
            if (w_dec) begin
                case (r_state)
                    S_START:  r_bit_idx <= '0;
                    S_DATA: begin
                        r_shreg   <= {w_vote, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    S_PARITY: r_par <= w_vote;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= w_load;
            if (w_load) begin
                r_data <= r_shreg;
                r_perr <= ^{r_shreg, r_par};
                r_ferr <= ~w_vote;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.rdy_rx     = r_rdy;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_parity.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : tb_uart_rx_parity
//  Brief    : Scoreboard bench for uart_rx_parity with randomized frames
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_uart_rx_parity;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 10_000;
    localparam int OVS     = 16;
    localparam int BIT_CLK = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_rdy = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_parity_if u_if();

    uart_rx_parity #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .OVS   (OVS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: even parity over data+parity bit, frame error when stop bit is 0.
    function automatic exp_t model(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
        e.perr = (($countones({d, par}) % 2) == 1);
        e.ferr = !stp;
        return e;
    endfunction

    always @(negedge clk) begin
        if (u_if.rdy_rx) begin
            check("rdy_width", {31'd0, prev_rdy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", u_if.data_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_out",   {24'd0, u_if.data_out},   {24'd0, mon_e.data});
                check("parity_err", {31'd0, u_if.parity_err}, {31'd0, mon_e.perr});
                check("frame_err",  {31'd0, u_if.frame_err},  {31'd0, mon_e.ferr});
            end
        end
        prev_rdy = u_if.rdy_rx;
    end

    task automatic idle(input int n);
        u_if.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp,
                        input int bt, input logic expect_it);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        if (expect_it) sb_q.push_back(model(d, par, stp));
        for (int i = 0; i < 11; i++) begin
            u_if.rxd = bits[i];
            repeat (bt) @(negedge clk);
        end
    endtask

    task automatic wait_busy_low(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (!u_if.busy) break;
            @(negedge clk);
        end
        check(name, {31'd0, u_if.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         bt;
        int         sel;

        u_if.rxd = 1'b1;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out",   {24'd0, u_if.data_out},   32'd0);
        check("rst_rdy_rx",     {31'd0, u_if.rdy_rx},     32'd0);
        check("rst_parity_err", {31'd0, u_if.parity_err}, 32'd0);
        check("rst_frame_err",  {31'd0, u_if.frame_err},  32'd0);
        check("rst_busy",       {31'd0, u_if.busy},       32'd0);
        rst = 1'b0;
        idle(20);

        send(8'h55, 1'b0, 1'b1, BIT_CLK, 1'b1);
        idle(50);

        // Back-to-back frames, no idle gap.
        send(8'h07, 1'b1, 1'b1, BIT_CLK, 1'b1);
        send(8'hA3, 1'b0, 1'b1, BIT_CLK, 1'b1);
        idle(50);

        send(8'h07, 1'b0, 1'b1, BIT_CLK, 1'b1);
        idle(50);

        // Start-bit glitch.
        u_if.rxd = 1'b0;
        repeat (40) @(negedge clk);
        u_if.rxd = 1'b1;
        check("glitch_busy", {31'd0, u_if.busy}, 32'd1);
        wait_busy_low(BIT_CLK, "glitch_idle");
        idle(50);

        // Break: stop low, line held low 3 more bits.
        send(8'h00, 1'b0, 1'b0, BIT_CLK, 1'b1);
        repeat (3 * BIT_CLK) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (150) @(negedge clk);
        check("break_busy", {31'd0, u_if.busy}, 32'd1);
        wait_busy_low(30, "break_idle");
        idle(20);
        send(8'h3C, 1'b0, 1'b1, BIT_CLK, 1'b1);
        idle(50);

        // Reset in the middle of a 0xFF frame.
        u_if.rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (4 * BIT_CLK) @(negedge clk);
        check("mid_busy", {31'd0, u_if.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_data_out",   {24'd0, u_if.data_out},   32'd0);
        check("arst_rdy_rx",     {31'd0, u_if.rdy_rx},     32'd0);
        check("arst_parity_err", {31'd0, u_if.parity_err}, 32'd0);
        check("arst_frame_err",  {31'd0, u_if.frame_err},  32'd0);
        check("arst_busy",       {31'd0, u_if.busy},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        send(8'h81, 1'b0, 1'b1, BIT_CLK, 1'b1);
        idle(50);

        // Random frames with +/-3% baud mismatch, bad parity and framing errors.
        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            sel = $urandom_range(0, 2);
            bt  = (sel == 0) ? 155 : ((sel == 1) ? 160 : 165);
            send(d, par, stp, bt, 1'b1);
            idle(stp ? $urandom_range(0, 100) : 200);
        end

        idle(400);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
